fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO and next generation of the single-entry, single-bit FIFO cell.
- Adds configurable data width and depth, a dequeue port, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
- Sits between producer/consumer blocks in one clock domain. Read data is first-word-fall-through.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of entries (>=2, any integer; not required to be a power of two)
- AF_LEVEL, 3, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
- CW, $clog2(DEPTH+1), count width (derived, not overridden)

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of contents and error flags
- enq  input  1  write request
- din  input  WIDTH  write data
- deq  input  1  read request (consumes head entry)
- dout  output  WIDTH  head entry while !empty; 0 while empty
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  CW  number of stored entries
- overflow  output  1  sticky: enq attempted while full and not accepted
- underflow  output  1  sticky: deq attempted while empty

Behaviour:
- Storage: DEPTH x WIDTH register array. wr_ptr and rd_ptr run 0..DEPTH-1 and wrap to 0 after DEPTH-1 (explicit compare, not power-of-two masking). count is held in a separate register.
- Reset (RST=1 at a clock edge) sets wr_ptr=0, rd_ptr=0, count=0, overflow=0 and underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0), dout=0. Array contents need not be cleared.
- RST has priority over flush, and flush has priority over enq/deq. Reset mid-operation discards all entries at that edge.
- flush=1 (RST=0) gives the same result as reset. enq/deq in the same cycle are ignored.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = enq & (!full | deq)
  - rd_acc = deq & !empty
- Full with enq & deq: both are accepted. Head is consumed and din is written, so count stays DEPTH.
- Empty with enq & deq: only the write is accepted, with no bypass. underflow is set and count becomes 1.
- wr_acc writes din to mem[wr_ptr] and advances wr_ptr. rd_acc advances rd_ptr.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- overflow is set when enq & full & !deq. underflow is set when deq & empty. Both hold until RST or flush.
- dout is combinational from mem[rd_ptr], gated to 0 when empty. A written entry becomes visible on dout the cycle after the write edge (write-to-read latency 1 cycle). After rd_acc, the next entry appears the following cycle.
- full, empty, almost_full, almost_empty are combinational decodes of the count register, so they reflect post-edge state with no extra lag.
- Data order is strictly FIFO across pointer wrap-around.

Test Plan:
- Reset and flags (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
  - RST=1 for 2 cycles -> count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, overflow=0, underflow=0.
- Fill and overflow:
  - enq 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_empty drops at count=2; almost_full rises at count=3; full=1 at count=4.
  - A 5th enq of 0x55 -> not stored, count=4, overflow=1 (sticky).
- Drain and underflow:
  - From the full state, deq 4 cycles -> dout 0x11,0x22,0x33,0x44 in order; empty=1 after the 4th.
  - A further deq -> underflow=1, count=0, dout=0.
- Wrap-around with DEPTH=3:
  - Interleave 7 enqs (0x01..0x07) and deqs keeping count<=2 -> output sequence 0x01..0x07 exactly, with pointers wrapping twice.
- Simultaneous enq/deq:
  - When full: enq 0xAA with deq -> count stays 4, old head leaves, 0xAA becomes the last entry, no overflow.
  - When empty: enq 0xBB with deq -> count=1, dout=0xBB the next cycle, underflow=1.
- Flush and reset priority:
  - With count=3 and overflow=1, assert flush with enq=1 -> count=0, empty=1, overflow=0, nothing written.
  - Assert RST and flush together mid-stream -> same reset state.

Source files
------------

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous FIFO with first-word-fall-through read data
// Provides occupancy count, programmable almost flags, flush, and sticky overflow/underflow.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             enq,
    input  logic [WIDTH-1:0] din,
    input  logic             deq,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Status decodes come straight from the count register, so they track post-edge state.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign dout         = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_acc = enq & (~full | deq);
    assign rd_acc = deq & ~empty;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (enq & full & ~deq);
        underflow_d = underflow_q | (deq & empty);

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_flush = 1'b0, a_enq = 1'b0, a_deq = 1'b0;
    logic [7:0] a_din = 8'h00;
    logic [7:0] a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [2:0] a_count;

    logic       b_flush = 1'b0, b_enq = 1'b0, b_deq = 1'b0;
    logic [7:0] b_din = 8'h00;
    logic [7:0] b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [1:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
        .CLK(clk), .RST(rst), .flush(a_flush), .enq(a_enq), .din(a_din), .deq(a_deq),
        .dout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ov), .underflow(a_un)
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1)) dut_b (
        .CLK(clk), .RST(rst), .flush(b_flush), .enq(b_enq), .din(b_din), .deq(b_deq),
        .dout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ov), .underflow(b_un)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic enq, input logic [7:0] din, input logic deq);
        a_enq = enq;
        a_din = din;
        a_deq = deq;
        tick();
        a_enq = 1'b0;
        a_deq = 1'b0;
    endtask

    task automatic step_b(input logic enq, input logic [7:0] din, input logic deq);
        b_enq = enq;
        b_din = din;
        b_deq = deq;
        tick();
        b_enq = 1'b0;
        b_deq = 1'b0;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_count"}, a_count, 0);
        chk({tag, "_empty"}, a_empty, 1);
        chk({tag, "_full"},  a_full, 0);
        chk({tag, "_ae"},    a_ae, 1);
        chk({tag, "_af"},    a_af, 0);
        chk({tag, "_dout"},  a_dout, 8'h00);
        chk({tag, "_ov"},    a_ov, 0);
        chk({tag, "_un"},    a_un, 0);
    endtask

    initial begin
        // Reset held for two edges
        rst = 1'b1;
        tick();
        tick();
        chk_a_reset("rst");
        chk("rst_b_empty", b_empty, 1);
        rst = 1'b0;

        // Fill
        step_a(1, 8'h11, 0);
        chk("fill1_count", a_count, 1); chk("fill1_ae", a_ae, 1); chk("fill1_dout", a_dout, 8'h11);
        chk("fill1_empty", a_empty, 0);
        step_a(1, 8'h22, 0);
        chk("fill2_count", a_count, 2); chk("fill2_ae", a_ae, 0); chk("fill2_af", a_af, 0);
        step_a(1, 8'h33, 0);
        chk("fill3_count", a_count, 3); chk("fill3_af", a_af, 1); chk("fill3_full", a_full, 0);
        step_a(1, 8'h44, 0);
        chk("fill4_count", a_count, 4); chk("fill4_full", a_full, 1); chk("fill4_ov", a_ov, 0);
        step_a(1, 8'h55, 0);
        chk("ovf_count", a_count, 4); chk("ovf_ov", a_ov, 1); chk("ovf_dout", a_dout, 8'h11);

        // Drain
        step_a(0, 8'h00, 1);
        chk("drain1_dout", a_dout, 8'h22); chk("drain1_count", a_count, 3); chk("drain1_full", a_full, 0);
        step_a(0, 8'h00, 1);
        chk("drain2_dout", a_dout, 8'h33);
        step_a(0, 8'h00, 1);
        chk("drain3_dout", a_dout, 8'h44); chk("drain3_ae", a_ae, 1);
        step_a(0, 8'h00, 1);
        chk("drain4_empty", a_empty, 1); chk("drain4_dout", a_dout, 8'h00);
        chk("drain4_ov_sticky", a_ov, 1); chk("drain4_un", a_un, 0);
        step_a(0, 8'h00, 1);
        chk("udf_un", a_un, 1); chk("udf_count", a_count, 0); chk("udf_dout", a_dout, 8'h00);

        // Flush clears sticky flags
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk_a_reset("flush0");

        // Simultaneous enq/deq while empty: write only, underflow set
        step_a(1, 8'hBB, 1);
        chk("sim_empty_count", a_count, 1); chk("sim_empty_dout", a_dout, 8'hBB);
        chk("sim_empty_un", a_un, 1);

        // Fill to full, then simultaneous enq/deq
        step_a(1, 8'h01, 0);
        step_a(1, 8'h02, 0);
        step_a(1, 8'h03, 0);
        chk("pre_sim_full", a_full, 1);
        step_a(1, 8'hAA, 1);
        chk("sim_full_count", a_count, 4); chk("sim_full_dout", a_dout, 8'h01);
        chk("sim_full_ov", a_ov, 0);
        step_a(0, 8'h00, 1);
        chk("sim_full_d1", a_dout, 8'h02);
        step_a(0, 8'h00, 1);
        chk("sim_full_d2", a_dout, 8'h03);
        step_a(0, 8'h00, 1);
        chk("sim_full_d3", a_dout, 8'hAA); chk("sim_full_d3_count", a_count, 1);
        step_a(0, 8'h00, 1);
        chk("sim_full_empty", a_empty, 1);

        // Flush with count=3 and overflow set, enq held high
        step_a(1, 8'hC1, 0);
        step_a(1, 8'hC2, 0);
        step_a(1, 8'hC3, 0);
        step_a(1, 8'hC4, 0);
        step_a(1, 8'hC5, 0);
        step_a(0, 8'h00, 1);
        chk("preflush_count", a_count, 3); chk("preflush_ov", a_ov, 1);
        a_flush = 1'b1;
        step_a(1, 8'hEE, 0);
        a_flush = 1'b0;
        chk("flush_count", a_count, 0); chk("flush_empty", a_empty, 1);
        chk("flush_ov", a_ov, 0); chk("flush_dout", a_dout, 8'h00);
        step_a(1, 8'h77, 0);
        chk("postflush_dout", a_dout, 8'h77); chk("postflush_count", a_count, 1);

        // Reset and flush together mid-stream
        step_a(1, 8'h78, 0);
        step_a(0, 8'h00, 1);
        step_a(0, 8'h00, 1);
        step_a(0, 8'h00, 1);
        chk("pre_rst_un", a_un, 1);
        step_a(1, 8'h79, 0);
        chk("pre_rst_count", a_count, 1);
        rst = 1'b1;
        a_flush = 1'b1;
        step_a(1, 8'h80, 1);
        rst = 1'b0;
        a_flush = 1'b0;
        chk_a_reset("rstflush");

        // DEPTH=3 wrap-around: pointers wrap twice over seven writes
        step_b(1, 8'h01, 0);
        chk("wrap_d01", b_dout, 8'h01);
        step_b(1, 8'h02, 0);
        chk("wrap_c2", b_count, 2); chk("wrap_af", b_af, 1); chk("wrap_head", b_dout, 8'h01);
        for (int k = 3; k <= 7; k++) begin
            step_b(1, 8'(k), 1);
            chk($sformatf("wrap_d%0d", k - 1), b_dout, k - 1);
            chk($sformatf("wrap_c%0d", k), b_count, 2);
        end
        step_b(0, 8'h00, 1);
        chk("wrap_d07", b_dout, 8'h07); chk("wrap_last_count", b_count, 1);
        step_b(0, 8'h00, 1);
        chk("wrap_empty", b_empty, 1); chk("wrap_ov", b_ov, 0); chk("wrap_un", b_un, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
